xbar_tgt_credit_buffer: RTL and testbench
=========================================

Name: xbar_tgt_credit_buffer

Overview:
- Target-side receive stage that sits directly downstream of one output port of the simplex crossbar when that crossbar runs with credit-based handshake.
- Accepts the crossbar's valid-only stream (data plus initiator address) into a buffer of NumCredits entries.
- Presents the buffered requests to the target with a valid/ready handshake.
- Returns one credit pulse to the crossbar per freed entry. After reset it issues the initial NumCredits credits that the crossbar port expects.

Parameters:
- NumIn, 4: number of crossbar initiators; ini_addr width is IniAddrWidth = max(1, $clog2(NumIn)).
- DataWidth, 32: payload width.
- NumCredits, 2: buffer depth and total credits in circulation; must be ≥1 and ≤15, otherwise $fatal at elaboration.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset.
- valid_i, in, 1: crossbar output valid; each high cycle consumes one credit and is a push.
- credit_o, out, 1: credit-return pulse to crossbar ready_i; one credit per high cycle.
- ini_addr_i, in, IniAddrWidth: initiator index of the pushed request.
- data_i, in, DataWidth: pushed payload.
- valid_o, out, 1: buffer head valid toward target.
- ready_i, in, 1: target accepts head.
- ini_addr_o, out, IniAddrWidth: head initiator index.
- data_o, out, DataWidth: head payload.
- usage_o, out, $clog2(NumCredits+1): current buffer occupancy.
- overflow_o, out, 1: sticky protocol-error flag.

Behaviour:
- Clocking and reset: one clock (clk_i); reset (rst_i) is asynchronous and active-high. It asserts asynchronously; it is released at a clock edge.
- Reset values: credit_o=0, valid_o=0, usage_o=0, overflow_o=0, ini_addr_o=0, data_o=0. The FIFO is emptied, the read and write pointers are 0, owe_q=NumCredits, and state=IDLE.
- FSM states:
  - IDLE: entered only via reset; moves unconditionally to RUN on the first clock edge after rst_i deasserts (cycle 0). No credits are issued in IDLE.
  - RUN: the only other state.
- Credit counter owe_q, width $clog2(NumCredits+1):
  - Increments on pop (valid_o & ready_i).
  - Decrements when credit_o is high.
  - A simultaneous pop and credit leaves it unchanged.
  - credit_o = (state==RUN) & (owe_q != 0), combinational from registers only (no path from ready_i or valid_i).
- Initial credits: with no pops, credit_o is high in cycles 1..NumCredits and then low.
- Credit return after a pop: a pop in cycle t gives credit_o high in cycle t+1 at the earliest. Multiple owed credits drain at one per cycle.
- Invariant, checked by assertion: usage + owe_q + credits held by the crossbar == NumCredits.
- Push: valid_i writes {ini_addr_i, data_i} at the write pointer. It is accepted in any state, because credits from the previous cycle are legal.
- Latency: registered storage, no fall-through. A push in cycle t makes valid_o high in cycle t+1 when the buffer was empty.
- Pop: valid_o & ready_i advances the read pointer. data_o and ini_addr_o are stable while valid_o & !ready_i.
- Pointer wrap-around: pointers wrap at NumCredits; NumCredits need not be a power of 2.
- Push and pop in the same cycle:
  - When full: both happen, usage is unchanged, no overflow.
  - When empty: the pushed entry is not visible until the next cycle; the pop is not possible because valid_o=0.
- Overflow (valid_i while full and no pop): the write is dropped, stored entries are untouched, overflow_o is set and stays set until reset, and a simulation assertion fires.
- usage_o: updates the cycle after the push or pop; maximum value NumCredits.
- Reset asserted mid-operation: all contents are discarded immediately and owe_q reloads to NumCredits. The initial credit sequence restarts after release. The crossbar port must be reset simultaneously.

Test Plan:
- NumCredits=2, release reset, ready_i=0, valid_i=0 -> credit_o=0 at cycle 0, high at cycles 1 and 2, low from cycle 3; usage_o=0.
- Push 0xA5A5A5A5 / ini 3 at cycle 3, ready_i=0 -> valid_o=1, data_o=0xA5A5A5A5, ini_addr_o=3 from cycle 4 and held; credit_o stays 0.
- Push at cycles 3 and 4, then ready_i=1 from cycle 6 -> pops at cycles 6 and 7, credit_o high at cycles 7 and 8, usage_o goes 2->1->0, FIFO order preserved.
- Buffer full (usage 2), then valid_i=1 and ready_i=1 in the same cycle -> usage_o stays 2, overflow_o stays 0, new entry appears after the older one, one credit pulse next cycle.
- Buffer full, ready_i=0, valid_i=1 with data 0xDEAD -> overflow_o=1 sticky, 0xDEAD is never output, the existing two entries drain intact.
- Reset pulse while usage=2 and owe=0 -> valid_o=0 and usage_o=0 immediately; after release, two credit pulses at cycles 1 and 2 again.

Source files
------------

// File: rtl/xbar_tgt_credit_buffer.sv
// Target-side receive buffer for one credit-mode crossbar output port.
// Stores pushed requests, presents them with valid/ready and returns one credit per freed entry.
module xbar_tgt_credit_buffer #(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumCredits   = 2,
  localparam int unsigned IniAddrWidth = (NumIn > 1) ? $clog2(NumIn) : 1,
  localparam int unsigned UsageWidth   = $clog2(NumCredits + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    credit_o,
  input  logic [IniAddrWidth-1:0] ini_addr_i,
  input  logic [DataWidth-1:0]    data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [IniAddrWidth-1:0] ini_addr_o,
  output logic [DataWidth-1:0]    data_o,
  output logic [UsageWidth-1:0]   usage_o,
  output logic                    overflow_o
);

  // state | meaning
  // IDLE  | held in reset; no credits issued, leaves on the first edge after release
  // RUN   | normal operation; owed credits returned one per cycle

  if (NumCredits < 1 || NumCredits > 15) begin : g_bad_cfg
    $fatal(1, "xbar_tgt_credit_buffer: NumCredits must be within 1..15");
  end

  localparam int unsigned EntryWidth = IniAddrWidth + DataWidth;
  localparam int unsigned PtrWidth   = (NumCredits > 1) ? $clog2(NumCredits) : 1;
  localparam logic [UsageWidth-1:0] UsageMax = UsageWidth'(NumCredits);
  localparam logic [PtrWidth-1:0]   PtrLast  = PtrWidth'(NumCredits - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [EntryWidth-1:0]   mem_q [NumCredits];
  logic [PtrWidth-1:0]     rd_ptr_q, wr_ptr_q;
  logic [UsageWidth-1:0]   usage_q, owe_q;
  logic                    overflow_q;
  logic                    full, pop, push, drop;

  // Credits the crossbar currently holds; only feeds the circulation check below.
  logic [UsageWidth:0]     held_q;
  logic                    viol_q;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrWidth'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_o = 1'b0;
    if (state_q == RUN && owe_q != '0) credit_o = 1'b1;
  end

  assign full    = (usage_q == UsageMax);
  assign valid_o = (usage_q != '0);
  assign pop     = valid_o & ready_i;
  assign push    = valid_i & (~full | pop);
  assign drop    = valid_i & full & ~pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCredits; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {ini_addr_i, data_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      usage_q    <= '0;
      owe_q      <= UsageMax;
      overflow_q <= 1'b0;
      held_q     <= '0;
      viol_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   usage_q <= usage_q + UsageWidth'(1);
        2'b01:   usage_q <= usage_q - UsageWidth'(1);
        default: usage_q <= usage_q;
      endcase
      case ({pop, credit_o})
        2'b10:   owe_q <= owe_q + UsageWidth'(1);
        2'b01:   owe_q <= owe_q - UsageWidth'(1);
        default: owe_q <= owe_q;
      endcase
      if (drop) overflow_q <= 1'b1;

      // A push with no credit outstanding breaks the credit loop; stop checking after that.
      if (valid_i && held_q == '0) viol_q <= 1'b1;
      case ({credit_o, valid_i && held_q != '0})
        2'b10:   held_q <= held_q + (UsageWidth+1)'(1);
        2'b01:   held_q <= held_q - (UsageWidth+1)'(1);
        default: held_q <= held_q;
      endcase

      assert (viol_q || ({1'b0, usage_q} + {1'b0, owe_q} + held_q) == (UsageWidth+1)'(NumCredits))
        else $error("xbar_tgt_credit_buffer: credit circulation broken");
      assert (!drop)
        else $warning("xbar_tgt_credit_buffer: push while full, entry dropped");
    end
  end

  assign {ini_addr_o, data_o} = mem_q[rd_ptr_q];
  assign usage_o    = usage_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_xbar_tgt_credit_buffer.sv
// Directed bench for xbar_tgt_credit_buffer with NumCredits=2; cycle n is the period after the n-th edge following reset release.
module tb_xbar_tgt_credit_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        credit_o;
  logic [1:0]  ini_addr_i;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  ini_addr_o;
  logic [31:0] data_o;
  logic [1:0]  usage_o;
  logic        overflow_o;

  int errors = 0;
  int checks = 0;

  xbar_tgt_credit_buffer #(.NumIn(4), .DataWidth(32), .NumCredits(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .credit_o   (credit_o),
    .ini_addr_i (ini_addr_i),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .ini_addr_o (ini_addr_o),
    .data_o     (data_o),
    .usage_o    (usage_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic push(input logic [1:0] ini, input logic [31:0] d);
    valid_i    = 1'b1;
    ini_addr_i = ini;
    data_i     = d;
  endtask

  task automatic idle_in();
    valid_i    = 1'b0;
    ini_addr_i = '0;
    data_i     = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    ready_i = 1'b0;
    idle_in();
    tick(); tick();
    chk("rst_credit", credit_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_usage", usage_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ini", ini_addr_o, 0);

    // initial credits
    rst_i = 1'b0;
    chk("c0_credit", credit_o, 0);
    tick(); chk("c1_credit", credit_o, 1); chk("c1_usage", usage_o, 0);
    tick(); chk("c2_credit", credit_o, 1);
    tick(); chk("c3_credit", credit_o, 0);

    // pushes at 3 and 4, held head, pops at 6 and 7
    push(2'd3, 32'hA5A5_A5A5);
    tick();
    chk("c4_valid", valid_o, 1); chk("c4_data", data_o, 32'hA5A5_A5A5);
    chk("c4_ini", ini_addr_o, 3); chk("c4_usage", usage_o, 1); chk("c4_credit", credit_o, 0);
    push(2'd1, 32'h1111_1111);
    tick(); idle_in();
    chk("c5_data_held", data_o, 32'hA5A5_A5A5); chk("c5_ini_held", ini_addr_o, 3);
    chk("c5_usage", usage_o, 2); chk("c5_credit", credit_o, 0);
    tick();
    chk("c6_data_held", data_o, 32'hA5A5_A5A5); chk("c6_credit", credit_o, 0);
    ready_i = 1'b1;
    tick();
    chk("c7_data", data_o, 32'h1111_1111); chk("c7_ini", ini_addr_o, 1);
    chk("c7_usage", usage_o, 1); chk("c7_credit", credit_o, 1);
    tick(); ready_i = 1'b0;
    chk("c8_usage", usage_o, 0); chk("c8_valid", valid_o, 0); chk("c8_credit", credit_o, 1);
    tick();
    chk("c9_credit", credit_o, 0);

    // fill, then push and pop together while full
    push(2'd0, 32'hCCCC_0001);
    tick();
    push(2'd1, 32'hCCCC_0002);
    tick();
    chk("full_usage", usage_o, 2); chk("full_head", data_o, 32'hCCCC_0001);
    push(2'd2, 32'hEEEE_0003);
    ready_i = 1'b1;
    tick(); idle_in(); ready_i = 1'b0;
    chk("pp_usage", usage_o, 2); chk("pp_ovf", overflow_o, 0);
    chk("pp_head", data_o, 32'hCCCC_0002); chk("pp_credit", credit_o, 1);
    tick();
    chk("pp_credit_once", credit_o, 0);
    ready_i = 1'b1;
    tick();
    chk("pp_newer", data_o, 32'hEEEE_0003); chk("pp_newer_ini", ini_addr_o, 2);
    chk("pp_drain_credit", credit_o, 1);
    tick(); ready_i = 1'b0;
    chk("pp_empty", valid_o, 0); chk("pp_empty_usage", usage_o, 0);
    tick();

    // overflow while full with no pop
    push(2'd0, 32'h0F0F_0F0F);
    tick();
    push(2'd1, 32'h1234_5678);
    tick();
    chk("of_pre_usage", usage_o, 2);
    push(2'd3, 32'h0000_DEAD);
    tick(); idle_in();
    chk("of_flag", overflow_o, 1); chk("of_usage", usage_o, 2);
    chk("of_head", data_o, 32'h0F0F_0F0F); chk("of_head_ini", ini_addr_o, 0);
    tick();
    chk("of_sticky", overflow_o, 1);
    ready_i = 1'b1;
    tick();
    chk("of_second", data_o, 32'h1234_5678); chk("of_second_ini", ini_addr_o, 1);
    tick(); ready_i = 1'b0;
    chk("of_drained", valid_o, 0); chk("of_drained_usage", usage_o, 0);
    chk("of_sticky2", overflow_o, 1);
    tick(); tick();

    // reset mid-operation with buffer full and nothing owed
    push(2'd2, 32'h2222_2222);
    tick();
    push(2'd3, 32'h3333_3333);
    tick(); idle_in();
    chk("mr_usage", usage_o, 2); chk("mr_credit", credit_o, 0);
    rst_i = 1'b1;
    #1;
    chk("mr_valid", valid_o, 0); chk("mr_usage0", usage_o, 0); chk("mr_ovf", overflow_o, 0);
    tick();
    rst_i = 1'b0;
    chk("mr_c0_credit", credit_o, 0);
    tick(); chk("mr_c1_credit", credit_o, 1);
    tick(); chk("mr_c2_credit", credit_o, 1);
    tick(); chk("mr_c3_credit", credit_o, 0); chk("mr_c3_valid", valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
